// File: rtl/vga_box_painter_if.sv
// Pixel-source bundle between the VGA timing generator side and vga_box_painter.
// master = timing/control side, slave = painter.
interface vga_box_painter_if #(
    parameter int unsigned HSYNC_BITS = 11,
    parameter int unsigned VSYNC_BITS = 11
);
    logic [HSYNC_BITS-1:0] hcount;
    logic [VSYNC_BITS-1:0] vcount;
    logic                  run;
    logic [11:0]           box_color;
    logic [11:0]           rgb;
    logic                  frame_tick;
    logic [HSYNC_BITS-1:0] box_x;
    logic [VSYNC_BITS-1:0] box_y;

    modport master (
        output hcount, vcount, run, box_color,
        input  rgb, frame_tick, box_x, box_y
    );

    modport slave (
        input  hcount, vcount, run, box_color,
        output rgb, frame_tick, box_x, box_y
    );
endinterface

// File: rtl/vga_box_painter.sv
// Bouncing-square pixel source aligned one cycle behind the VGA timing generator counters.
// Optional white active-area border when VGA_BOX_BORDER_EN is defined.
module vga_box_painter #(
    parameter int unsigned HSYNC_BITS = 11,
    parameter int unsigned VSYNC_BITS = 11,
    parameter int unsigned HD         = 1280,
    parameter int unsigned HR         = 112,
    parameter int unsigned HB         = 248,
    parameter int unsigned HMAX       = 1687,
    parameter int unsigned VD         = 1024,
    parameter int unsigned VR         = 3,
    parameter int unsigned VB         = 38,
    parameter int unsigned VMAX       = 1065,
    parameter int unsigned BOX        = 64,
    parameter int unsigned STEP       = 4
) (
    input  logic             clk,
    input  logic             arstn,
    vga_box_painter_if.slave vga
);
    localparam int unsigned HW = HSYNC_BITS;
    localparam int unsigned VW = VSYNC_BITS;

    // Edge sums carry one extra bit so box+BOX+STEP can never wrap.
    localparam logic [HW:0]   H_START = (HW+1)'(HR + HB);
    localparam logic [HW:0]   H_END   = (HW+1)'(HR + HB + HD);
    localparam logic [HW:0]   H_LIM   = (HW+1)'(HD);
    localparam logic [HW:0]   H_BOX   = (HW+1)'(BOX);
    localparam logic [HW:0]   H_STEP  = (HW+1)'(STEP);
    localparam logic [HW-1:0] H_LAST  = HW'(HMAX);
    localparam logic [HW-1:0] H_PARK  = HW'(HD - BOX);
    localparam logic [HW-1:0] H_INC   = HW'(STEP);

    localparam logic [VW:0]   V_START = (VW+1)'(VR + VB);
    localparam logic [VW:0]   V_END   = (VW+1)'(VR + VB + VD);
    localparam logic [VW:0]   V_LIM   = (VW+1)'(VD);
    localparam logic [VW:0]   V_BOX   = (VW+1)'(BOX);
    localparam logic [VW:0]   V_STEP  = (VW+1)'(STEP);
    localparam logic [VW-1:0] V_LAST  = VW'(VMAX);
    localparam logic [VW-1:0] V_PARK  = VW'(VD - BOX);
    localparam logic [VW-1:0] V_INC   = VW'(STEP);

`ifdef VGA_BOX_BORDER_EN
    localparam logic [HW-1:0] H_RIGHT = HW'(HD - 1);
    localparam logic [VW-1:0] V_BOTTOM = VW'(VD - 1);
`endif

    logic [HW-1:0] box_x_q, box_x_nxt_c;
    logic [VW-1:0] box_y_q, box_y_nxt_c;
    logic          dir_x_neg_q, dir_x_neg_nxt_c;
    logic          dir_y_neg_q, dir_y_neg_nxt_c;
    logic [11:0]   colour_q;
    logic [11:0]   rgb_q;
    logic          tick_q;

    logic [HW:0]   hc_ext_c;
    logic [VW:0]   vc_ext_c;
    logic [HW-1:0] x_c;
    logic [VW-1:0] y_c;
    logic          active_c;
    logic          in_box_c;
    logic          frame_end_c;
    logic [11:0]   pixel_c;

    assign hc_ext_c    = {1'b0, vga.hcount};
    assign vc_ext_c    = {1'b0, vga.vcount};
    assign active_c    = (hc_ext_c >= H_START) && (hc_ext_c < H_END) &&
                         (vc_ext_c >= V_START) && (vc_ext_c < V_END);
    assign x_c         = HW'(hc_ext_c - H_START);
    assign y_c         = VW'(vc_ext_c - V_START);
    assign in_box_c    = (x_c >= box_x_q) && ({1'b0, x_c} < ({1'b0, box_x_q} + H_BOX)) &&
                         (y_c >= box_y_q) && ({1'b0, y_c} < ({1'b0, box_y_q} + V_BOX));
    assign frame_end_c = (vga.hcount == H_LAST) && (vga.vcount == V_LAST);

    // Pixel colour for the current counters; border overrides the box.
    always_comb begin
        pixel_c = 12'h000;
        if (active_c) begin
            if (in_box_c) begin
                pixel_c = colour_q;
            end
`ifdef VGA_BOX_BORDER_EN
            if ((x_c == '0) || (x_c == H_RIGHT) || (y_c == '0) || (y_c == V_BOTTOM)) begin
                pixel_c = 12'hFFF;
            end
`endif
        end
    end

    // Per-axis bounce: park against the far edge, or clamp at zero, then reverse.
    always_comb begin
        box_x_nxt_c     = box_x_q;
        dir_x_neg_nxt_c = dir_x_neg_q;
        if (!dir_x_neg_q) begin
            if (({1'b0, box_x_q} + H_BOX + H_STEP) > H_LIM) begin
                box_x_nxt_c     = H_PARK;
                dir_x_neg_nxt_c = 1'b1;
            end else begin
                box_x_nxt_c = box_x_q + H_INC;
            end
        end else begin
            if (box_x_q < H_INC) begin
                box_x_nxt_c     = '0;
                dir_x_neg_nxt_c = 1'b0;
            end else begin
                box_x_nxt_c = box_x_q - H_INC;
            end
        end
    end

    always_comb begin
        box_y_nxt_c     = box_y_q;
        dir_y_neg_nxt_c = dir_y_neg_q;
        if (!dir_y_neg_q) begin
            if (({1'b0, box_y_q} + V_BOX + V_STEP) > V_LIM) begin
                box_y_nxt_c     = V_PARK;
                dir_y_neg_nxt_c = 1'b1;
            end else begin
                box_y_nxt_c = box_y_q + V_INC;
            end
        end else begin
            if (box_y_q < V_INC) begin
                box_y_nxt_c     = '0;
                dir_y_neg_nxt_c = 1'b0;
            end else begin
                box_y_nxt_c = box_y_q - V_INC;
            end
        end
    end

    // Position, direction and colour only change at frame end.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rgb_q       <= 12'h000;
            tick_q      <= 1'b0;
            colour_q    <= 12'h000;
            box_x_q     <= '0;
            box_y_q     <= '0;
            dir_x_neg_q <= 1'b0;
            dir_y_neg_q <= 1'b0;
        end else begin
            rgb_q  <= pixel_c;
            tick_q <= frame_end_c;
            if (frame_end_c) begin
                colour_q <= vga.box_color;
                if (vga.run) begin
                    box_x_q     <= box_x_nxt_c;
                    box_y_q     <= box_y_nxt_c;
                    dir_x_neg_q <= dir_x_neg_nxt_c;
                    dir_y_neg_q <= dir_y_neg_nxt_c;
                end
            end
        end
    end

    assign vga.rgb        = rgb_q;
    assign vga.frame_tick = tick_q;
    assign vga.box_x      = box_x_q;
    assign vga.box_y      = box_y_q;
endmodule
